// File: rtl/ahb_arb_pkg.sv
// Shared encodings and the round-robin helper for the AHB slave-port arbiter.
package ahb_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int ARB_MAX_M = 4;
    localparam int ARB_OWN_W = 2;

    // First requester strictly after owner, wrapping; owner itself is the last candidate.
    function automatic logic [ARB_OWN_W-1:0] rr_next(
        input logic [ARB_OWN_W-1:0] owner,
        input logic [ARB_MAX_M-1:0] req,
        input int                   n
    );
        logic [ARB_OWN_W-1:0] pick;
        logic [ARB_OWN_W-1:0] idx;
        pick = owner;
        for (int k = ARB_MAX_M; k >= 1; k--) begin
            if (k <= n) begin
                idx = ARB_OWN_W'((int'(owner) + k) % n);
                if (req[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin next-owner select over NUM_MASTERS requesters.
module ahb_rr_picker
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int OWNER_W     = 2
) (
    input  logic [OWNER_W-1:0]     owner_i,
    input  logic [NUM_MASTERS-1:0] req_i,
    output logic [OWNER_W-1:0]     next_o,
    output logic                   any_o
);

    logic [ARB_MAX_M-1:0] req_ext;

    always_comb begin
        req_ext = ARB_MAX_M'(req_i);
        next_o  = OWNER_W'(rr_next(ARB_OWN_W'(owner_i), req_ext, NUM_MASTERS));
        any_o   = |req_i;
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Round-robin sharing of one AHB-lite slave port among NUM_MASTERS requesters.
// Optional ARB_BURST_HOLD_EN lets an owner keep the grant for up to MAX_HOLD transfers.
module ahb_slave_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int OWNER_W     = 2,
    parameter int ADDR_W      = 32,
`ifdef ARB_BURST_HOLD_EN
    parameter int MAX_HOLD    = 4,
`endif
    parameter int DATA_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]        m_write,
    output logic [NUM_MASTERS-1:0]        m_gnt,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]        m_done,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic                          s_hsel,
    output logic                          s_hready,
    output logic [ADDR_W-1:0]             s_haddr,
    output logic                          s_hwrite,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic                          s_hresp,
    input  logic                          s_hreadyout
);

    localparam int SLOTS = 2 ** OWNER_W;

    arb_state_e               state_q, state_d;
    logic [OWNER_W-1:0]       owner_q, owner_d;
    logic                     dp_valid_q, dp_valid_d;
    logic [OWNER_W-1:0]       dp_owner_q, dp_owner_d;
    logic                     dp_write_q, dp_write_d;
    logic [NUM_MASTERS-1:0]   done_q, done_d;
    logic [NUM_MASTERS-1:0]   err_q, err_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
`ifdef ARB_BURST_HOLD_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    logic [HOLD_W-1:0]        hold_q, hold_d;
`endif

    logic [ADDR_W-1:0]        addr_arr [SLOTS];
    logic [SLOTS-1:0]         req_ext;
    logic [SLOTS-1:0]         write_ext;
    logic                     bus_rdy, accept, complete;
    logic [OWNER_W-1:0]       rr_owner;
    logic                     rr_any;

    // Pad the master views to a power-of-two so owner indexes them directly.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < NUM_MASTERS) begin : g_used
            assign addr_arr[i]  = m_addr[i*ADDR_W +: ADDR_W];
            assign req_ext[i]   = m_req[i];
            assign write_ext[i] = m_write[i];
        end else begin : g_unused
            assign addr_arr[i]  = '0;
            assign req_ext[i]   = 1'b0;
            assign write_ext[i] = 1'b0;
        end
    end

    ahb_rr_picker #(
        .NUM_MASTERS(NUM_MASTERS),
        .OWNER_W    (OWNER_W)
    ) u_picker (
        .owner_i(owner_q),
        .req_i  (m_req),
        .next_o (rr_owner),
        .any_o  (rr_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_W'(NUM_MASTERS - 1);
            dp_valid_q <= 1'b0;
            dp_owner_q <= '0;
            dp_write_q <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q    <= '0;
`ifdef ARB_BURST_HOLD_EN
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            dp_valid_q <= dp_valid_d;
            dp_owner_q <= dp_owner_d;
            dp_write_q <= dp_write_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
`ifdef ARB_BURST_HOLD_EN
            hold_q     <= hold_d;
`endif
        end
    end

    // Arbitration only moves on bus-ready cycles, so wait states freeze owner and address.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        dp_valid_d = dp_valid_q;
        dp_owner_d = dp_owner_q;
        dp_write_d = dp_write_q;
        done_d     = '0;
        err_d      = '0;
        rdata_d    = rdata_q;
`ifdef ARB_BURST_HOLD_EN
        hold_d     = hold_q;
`endif
        if (bus_rdy) begin
`ifdef ARB_BURST_HOLD_EN
            if (accept && (int'(hold_q) + 1 < MAX_HOLD)) begin
                hold_d = hold_q + HOLD_W'(1);
            end else if (rr_any) begin
                state_d = ARB_GRANT;
                owner_d = rr_owner;
                hold_d  = '0;
            end else begin
                state_d = ARB_IDLE;
                hold_d  = '0;
            end
`else
            if (rr_any) begin
                state_d = ARB_GRANT;
                owner_d = rr_owner;
            end else begin
                state_d = ARB_IDLE;
            end
`endif
        end
        if (accept) begin
            dp_valid_d = 1'b1;
            dp_owner_d = owner_q;
            dp_write_d = s_hwrite;
        end else if (complete) begin
            dp_valid_d = 1'b0;
        end
        if (complete) begin
            done_d  = NUM_MASTERS'(1) << dp_owner_q;
            err_d   = (s_hresp == HRESP_ERROR) ? done_d : '0;
            rdata_d = dp_write_q ? '0 : s_rdata;
        end
    end

    always_comb begin
        bus_rdy  = ~dp_valid_q | s_hreadyout;
        s_hsel   = (state_q == ARB_GRANT) & req_ext[owner_q];
        s_haddr  = s_hsel ? addr_arr[owner_q] : '0;
        s_hwrite = s_hsel & write_ext[owner_q];
        s_hready = bus_rdy;
        m_gnt    = (state_q == ARB_GRANT) ? (NUM_MASTERS'(1) << owner_q) : '0;
        accept   = s_hsel & bus_rdy;
        complete = dp_valid_q & s_hreadyout;
        m_done   = done_q;
        m_err    = err_q;
        m_rdata  = rdata_q;
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(m_gnt));

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed self-checking bench for ahb_slave_arbiter (default build, two masters).
module tb_ahb_slave_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_req;
    logic [63:0] m_addr;
    logic [1:0]  m_write;
    logic [1:0]  m_gnt;
    logic [31:0] m_rdata;
    logic [1:0]  m_done;
    logic [1:0]  m_err;
    logic        s_hsel;
    logic        s_hready;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [31:0] s_rdata;
    logic        s_hresp;
    logic        s_hreadyout;

    int checks   = 0;
    int failures = 0;
    int n0       = 0;
    int n1       = 0;

    always #5 clk = ~clk;

    ahb_slave_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .m_req      (m_req),
        .m_addr     (m_addr),
        .m_write    (m_write),
        .m_gnt      (m_gnt),
        .m_rdata    (m_rdata),
        .m_done     (m_done),
        .m_err      (m_err),
        .s_hsel     (s_hsel),
        .s_hready   (s_hready),
        .s_haddr    (s_haddr),
        .s_hwrite   (s_hwrite),
        .s_rdata    (s_rdata),
        .s_hresp    (s_hresp),
        .s_hreadyout(s_hreadyout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; m_req = '0; m_addr = '0; m_write = '0;
        s_rdata = '0; s_hresp = 1'b0; s_hreadyout = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",    m_gnt,    2'b00);
        chk("rst_done",   m_done,   2'b00);
        chk("rst_err",    m_err,    2'b00);
        chk("rst_hsel",   s_hsel,   1'b0);
        chk("rst_hready", s_hready, 1'b1);
        chk("rst_haddr",  s_haddr,  32'h0);
        chk("rst_hwrite", s_hwrite, 1'b0);
        chk("rst_rdata",  m_rdata,  32'h0);
        reset = 1'b1;

        // Both masters requesting: grants alternate starting from master 0.
        m_addr = {32'h200, 32'h100};
        s_rdata = 32'h55;
        m_req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i < 6) begin
                chk("rr_gnt",   m_gnt,   (i % 2 == 0) ? 2'b01 : 2'b10);
                chk("rr_haddr", s_haddr, (i % 2 == 0) ? 32'h100 : 32'h200);
            end
            if (i == 6) m_req = 2'b00;
            n0 += int'(m_done[0]);
            n1 += int'(m_done[1]);
        end
        chk("rr_done0", n0, 3);
        chk("rr_done1", n1, 3);

        // Single read from master 0.
        m_addr = {32'h200, 32'h0};
        m_write = 2'b00;
        s_rdata = 32'hA5A5_0001;
        m_req = 2'b01;
        tick();
        chk("rd_gnt",    m_gnt,    2'b01);
        chk("rd_hsel",   s_hsel,   1'b1);
        chk("rd_haddr",  s_haddr,  32'h0);
        chk("rd_hwrite", s_hwrite, 1'b0);
        tick();
        m_req = 2'b00;
        chk("rd_done_early", m_done, 2'b00);
        tick();
        chk("rd_done",  m_done,  2'b01);
        chk("rd_rdata", m_rdata, 32'hA5A5_0001);
        chk("rd_err",   m_err,   2'b00);
        tick();
        chk("rd_done_clr", m_done, 2'b00);
        chk("rd_idle_gnt", m_gnt,  2'b00);

        // Master 1 write with two wait states.
        m_addr = {32'h1, 32'h0};
        m_write = 2'b10;
        s_rdata = 32'hDEAD_0000;
        m_req = 2'b10;
        tick();
        chk("wr_gnt",    m_gnt,    2'b10);
        chk("wr_haddr",  s_haddr,  32'h1);
        chk("wr_hwrite", s_hwrite, 1'b1);
        tick();
        m_req = 2'b00;
        s_hreadyout = 1'b0;
        #1;
        chk("wr_hready", s_hready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wr_wait_gnt",  m_gnt,  2'b10);
            chk("wr_wait_done", m_done, 2'b00);
        end
        s_hreadyout = 1'b1;
        tick();
        chk("wr_done",  m_done,  2'b10);
        chk("wr_err",   m_err,   2'b00);
        chk("wr_rdata", m_rdata, 32'h0);
        tick();
        chk("wr_done_clr", m_done, 2'b00);

        // Two-cycle error to master 0 while master 1 waits its turn.
        m_write = 2'b00;
        m_addr = {32'h80, 32'h40};
        s_rdata = 32'h0BAD;
        m_req = 2'b01;
        tick();
        chk("er_gnt0", m_gnt, 2'b01);
        m_req = 2'b11;
        tick();
        m_req = 2'b10;
        s_hreadyout = 1'b0;
        s_hresp = 1'b1;
        #1;
        chk("er_gnt1",   m_gnt,    2'b10);
        chk("er_haddr1", s_haddr,  32'h80);
        chk("er_hready", s_hready, 1'b0);
        tick();
        chk("er_hold_gnt",  m_gnt,  2'b10);
        chk("er_hold_done", m_done, 2'b00);
        s_hreadyout = 1'b1;
        #1;
        chk("er_hold_haddr", s_haddr,  32'h80);
        chk("er_hready2",    s_hready, 1'b1);
        tick();
        chk("er_done", m_done, 2'b01);
        chk("er_err",  m_err,  2'b01);
        m_req = 2'b00;
        s_hresp = 1'b0;
        s_rdata = 32'h1234;
        tick();
        chk("er_m1_done",  m_done,  2'b10);
        chk("er_m1_err",   m_err,   2'b00);
        chk("er_m1_rdata", m_rdata, 32'h1234);
        tick();

        // Asynchronous reset during a pending data phase.
        m_addr = {32'h300, 32'h0};
        m_req = 2'b10;
        tick();
        tick();
        m_req = 2'b00;
        s_hreadyout = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("ar_gnt",    m_gnt,    2'b00);
        chk("ar_hready", s_hready, 1'b1);
        chk("ar_hsel",   s_hsel,   1'b0);
        chk("ar_done",   m_done,   2'b00);
        chk("ar_rdata",  m_rdata,  32'h0);
        tick();
        s_hreadyout = 1'b1;
        reset = 1'b1;
        tick();
        chk("ar_nodone", m_done, 2'b00);
        m_req = 2'b11;
        tick();
        chk("ar_first_gnt", m_gnt, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
